mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sits directly upstream of the main RAM model, between the instruction-cache and data-cache miss ports and the RAM's 128-bit line interface.
- Accepts one line request at a time from either cache, with round-robin arbitration on conflicts.
- Holds the RAM address and data stable for a programmable access latency, then issues a one-cycle write strobe or captures the read line.
- Returns the line to the winning cache with a one-cycle ready pulse.

Parameters:
- LATENCY, 5, number of cycles a request stays in BUSY (legal range 1..15).
- ADDR_W, 26, line-address width (matches the RAM request/write address).
- LINE_W, 128, line width in bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- ic_req  input  1  icache line read request; held until ic_ready.
- ic_addr  input  ADDR_W  icache line address.
- ic_ready  output  1  one-cycle pulse: ic_data valid.
- ic_data  output  LINE_W  returned icache line.
- dc_req  input  1  dcache request; held until dc_ready.
- dc_we  input  1  1 = line write, 0 = line read.
- dc_addr  input  ADDR_W  dcache line address.
- dc_wdata  input  LINE_W  line to write.
- dc_ready  output  1  one-cycle pulse: dc_data valid (read) or write committed.
- dc_data  output  LINE_W  returned dcache line.
- data_requested  output  ADDR_W  RAM read line address.
- where_to_write  output  ADDR_W  RAM write line address.
- data_to_write  output  LINE_W  RAM write data.
- write_to_mem  output  1  RAM write strobe.
- data_returned  input  LINE_W  RAM read data (combinational from data_requested).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE, cnt=0, last_grant=IC.
  - All outputs are 0, including the latched addr/wdata/we registers.
- FSM states: IDLE, BUSY, DONE.
- IDLE, sampled at edge E0:
  - If exactly one req is high, grant it.
  - If both are high, grant the source not equal to last_grant (first tie after reset goes to DC).
  - On grant: latch addr, wdata and we (we forced 0 for IC); set owner and last_grant=owner; cnt=LATENCY-1; go to BUSY.
  - No req: stay in IDLE.
- BUSY:
  - data_requested = where_to_write = latched addr; data_to_write = latched wdata.
  - All three stay stable for the whole BUSY period.
  - Each edge with cnt!=0: cnt decrements.
  - Edge with cnt==0: if read, capture data_returned into the owner's data register; go to DONE.
- write_to_mem = (state==BUSY && cnt==0 && latched we), combinational and high for exactly one cycle. The RAM is level-sensitive, so any longer pulse is a bug.
- DONE:
  - Owner's ready is 1 for exactly this one cycle; the non-owner's ready stays 0.
  - Next edge goes to IDLE.
- Latency: ready is high in the cycle after edge E0+LATENCY.
- Minimum request spacing: LATENCY+2 cycles. A requester that keeps req high after its ready is making a new request.
- Data outputs:
  - ic_data and dc_data hold their last captured value until the next read capture for that port.
  - A dcache write leaves dc_data unchanged.
- req deasserted mid-transaction: the transaction still completes (the write still commits), ready still pulses, and the requester ignores it.
- Inputs changing during BUSY (addr, wdata, we, req of the owner) have no effect; only the latched copies are used.
- LATENCY=1: BUSY lasts one cycle; write_to_mem is high in that same cycle.
- Reset during BUSY:
  - Immediate abort with no write strobe; outputs go to 0.
  - Any write in flight is not committed unless its strobe cycle already completed.
- cnt width: 4 bits.

Decomposition:
- Shared package mem_pkg:
  - typedef arb_state_t {IDLE, BUSY, DONE};
  - typedef src_t {SRC_IC, SRC_DC};
  - constants MEM_ADDR_W=26, MEM_LINE_W=128.
- One natural sub-module: rr_arbiter2 (2-input round-robin grant with a last_grant register, updated on accept).
- Counter and FSM stay in mem_arbiter.

Test Plan:
- IC read, LATENCY=5, ic_addr=0x400, RAM line 0x400 = words {0x8420_0000, 0x0003_3002, 0x0018_A518, 0x0800_0E0A} → data_requested=0x400 for 5 cycles; ic_ready pulses once, 6 cycles after the accept edge; ic_data equals that line; write_to_mem stays 0.
- DC write, dc_addr=0x100, dc_wdata=128'hDEAD…BEEF → write_to_mem high exactly 1 cycle, with where_to_write=0x100 and the data stable; a later dc read of 0x100 returns DEAD…BEEF.
- ic_req and dc_req both raised at the same edge just after reset → DC served first, then IC. Both raised again → IC served first, then DC (alternation).
- Back-to-back: IC holds req high through ic_ready → second transaction accepted 2 cycles after the first ready; exactly one ready pulse per transaction.
- reset=0 asserted mid-BUSY of a DC write → all outputs 0 asynchronously; no write_to_mem pulse; the RAM line is unchanged after recovery.
- LATENCY=1 build: DC write then read of the same line → write_to_mem pulse coincides with the single BUSY cycle; each ready comes 2 cycles after accept; the read returns the written line.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and widths for the cache-miss arbiter in front of the main RAM.
package mem_pkg;
  localparam int unsigned MEM_ADDR_W = 26;
  localparam int unsigned MEM_LINE_W = 128;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
  typedef enum logic {SRC_IC, SRC_DC} src_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; the last winner loses the next tie.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_ic,
  input  logic req_dc,
  input  logic accept,
  output logic grant_valid_c,
  output src_t grant_c
);

  src_t last_q, last_d;

  always_comb begin
    grant_valid_c = req_ic | req_dc;
    grant_c       = SRC_IC;
    last_d        = last_q;
    if (req_ic && req_dc) begin
      grant_c = (last_q == SRC_IC) ? SRC_DC : SRC_IC;
    end else if (req_dc) begin
      grant_c = SRC_DC;
    end
    if (accept && grant_valid_c) begin
      last_d = grant_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= SRC_IC;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache/dcache line requests onto the RAM line port with a fixed
// access latency, then pulses the winner's ready for one cycle.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 5,
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned LINE_W  = MEM_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_data,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_data,
  output logic [ADDR_W-1:0] data_requested,
  output logic [ADDR_W-1:0] where_to_write,
  output logic [LINE_W-1:0] data_to_write,
  output logic              write_to_mem,
  input  logic [LINE_W-1:0] data_returned
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  src_t              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] ic_data_q, ic_data_d;
  logic [LINE_W-1:0] dc_data_q, dc_data_d;
  logic              ic_ready_q, ic_ready_d;
  logic              dc_ready_q, dc_ready_d;
  logic              grant_valid_c;
  src_t              grant_c;
  logic              accept_c;

  assign accept_c = (state_q == IDLE) && grant_valid_c;

  rr_arbiter2 u_rr (
    .clk           (clk),
    .reset         (reset),
    .req_ic        (ic_req),
    .req_dc        (dc_req),
    .accept        (accept_c),
    .grant_valid_c (grant_valid_c),
    .grant_c       (grant_c)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_data_d  = ic_data_q;
    dc_data_d  = dc_data_q;
    ic_ready_d = 1'b0;
    dc_ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          owner_d = grant_c;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
          if (grant_c == SRC_DC) begin
            addr_d  = dc_addr;
            wdata_d = dc_wdata;
            we_d    = dc_we;
          end else begin
            addr_d  = ic_addr;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Last BUSY cycle: the write strobe is up now, or the read line is valid.
          state_d = DONE;
          if (owner_q == SRC_DC) begin
            dc_ready_d = 1'b1;
            if (!we_q) dc_data_d = data_returned;
          end else begin
            ic_ready_d = 1'b1;
            ic_data_d  = data_returned;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= SRC_IC;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_data_q  <= '0;
      dc_data_q  <= '0;
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_data_q  <= ic_data_d;
      dc_data_q  <= dc_data_d;
      ic_ready_q <= ic_ready_d;
      dc_ready_q <= dc_ready_d;
    end
  end

  // The RAM is level-sensitive: the strobe must cover only the final BUSY cycle.
  assign write_to_mem   = (state_q == BUSY) && (cnt_q == '0) && we_q;
  assign data_requested = addr_q;
  assign where_to_write = addr_q;
  assign data_to_write  = wdata_q;
  assign ic_ready       = ic_ready_q;
  assign dc_ready       = dc_ready_q;
  assign ic_data        = ic_data_q;
  assign dc_data        = dc_data_q;

endmodule
